// File: rtl/wbm_cmd_bridge.sv
// wbm_cmd_bridge: byte-stream command packets -> one classic Wishbone cycle
// -> status/data response byte stream.
// Packet: OP, ADR[31:0] MSB first, DAT[31:0] MSB first (writes only).
// OP[3:0]: 1 = read, 2 = write, anything else illegal (status FF). OP[7:4] = byte selects.
// Optional build macro WBM_CMD_GAP_TIMEOUT_EN: aborts a partial packet after
// GAP_CYCLES idle cycles with status 03. Without it, partial packets wait forever.
`timescale 1ns/1ps
module wbm_cmd_bridge #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 4096
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  cmd_data_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam logic [2:0] S_OP      = 3'd0;
    localparam logic [2:0] S_ADR     = 3'd1;
    localparam logic [2:0] S_DAT     = 3'd2;
    localparam logic [2:0] S_BUS     = 3'd3;
    localparam logic [2:0] S_RSP_ST  = 3'd4;
    localparam logic [2:0] S_RSP_DAT = 3'd5;

    localparam logic [7:0] ST_ACK = 8'h00;
    localparam logic [7:0] ST_ERR = 8'h01;
    localparam logic [7:0] ST_TMO = 8'h02;
    localparam logic [7:0] ST_GAP = 8'h03;
    localparam logic [7:0] ST_BAD = 8'hFF;

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]    state_reg, state_next;
    logic [1:0]    byte_cnt_reg;
    logic          cmd_ready_reg;
    logic          we_reg;
    logic [3:0]    sel_reg;
    logic [31:0]   adr_shift_reg, dat_shift_reg, rd_data_reg;
    logic          wbm_cyc_reg, wbm_we_reg;
    logic [3:0]    wbm_sel_reg;
    logic [31:0]   wbm_adr_reg, wbm_dat_reg;
    logic [7:0]    rsp_data_reg;
    logic          rsp_valid_reg;
    logic [TW-1:0] tmo_cnt_reg;

    logic          cmd_fire, rsp_fire, op_legal, tmo_hit, bus_done, gap_hit;
    logic [7:0]    bus_status;

    assign cmd_fire = cmd_valid_i & cmd_ready_reg;
    assign rsp_fire = rsp_valid_reg & rsp_ready_i;
    assign op_legal = (cmd_data_i[3:0] == 4'h1) || (cmd_data_i[3:0] == 4'h2);
    assign tmo_hit  = (tmo_cnt_reg == TMO_LAST);
    assign bus_done = wbm_err_i | wbm_ack_i | tmo_hit;

    assign cmd_ready_o = cmd_ready_reg;
    assign rsp_data_o  = rsp_data_reg;
    assign rsp_valid_o = rsp_valid_reg;
    assign wbm_cyc_o   = wbm_cyc_reg;
    assign wbm_stb_o   = wbm_cyc_reg;
    assign wbm_we_o    = wbm_we_reg;
    assign wbm_sel_o   = wbm_sel_reg;
    assign wbm_adr_o   = wbm_adr_reg;
    assign wbm_dat_o   = wbm_dat_reg;

    // Completion status with err taking precedence over ack, ack over timeout
    always_comb begin
        bus_status = ST_TMO;
        if (wbm_err_i) begin
            bus_status = ST_ERR;
        end else if (wbm_ack_i) begin
            bus_status = ST_ACK;
        end
    end

`ifdef WBM_CMD_GAP_TIMEOUT_EN
    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    logic [GW-1:0] gap_cnt_reg;

    assign gap_hit = !cmd_fire && (gap_cnt_reg == GAP_LAST);

    // Count consecutive idle cycles inside a partially received packet
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            gap_cnt_reg <= '0;
        end else if (((state_reg == S_ADR) || (state_reg == S_DAT)) && !cmd_fire && !gap_hit) begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
        end else begin
            gap_cnt_reg <= '0;
        end
    end
`else
    // Without the gap timeout a partial packet never aborts; the expression is
    // constant false and only keeps GAP_CYCLES referenced.
    assign gap_hit = (GAP_CYCLES < 0);
`endif

    // Next-state decode for the packet/bus/response sequencer
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_OP: begin
                if (cmd_fire) state_next = op_legal ? S_ADR : S_RSP_ST;
            end
            S_ADR: begin
                if (cmd_fire) begin
                    if (byte_cnt_reg == 2'd3) state_next = we_reg ? S_DAT : S_BUS;
                end else if (gap_hit) begin
                    state_next = S_RSP_ST;
                end
            end
            S_DAT: begin
                if (cmd_fire) begin
                    if (byte_cnt_reg == 2'd3) state_next = S_BUS;
                end else if (gap_hit) begin
                    state_next = S_RSP_ST;
                end
            end
            S_BUS: begin
                if (bus_done) state_next = S_RSP_ST;
            end
            S_RSP_ST: begin
                // Only a successful read carries data bytes after the status
                if (rsp_fire) state_next = ((rsp_data_reg == ST_ACK) && !we_reg) ? S_RSP_DAT : S_OP;
            end
            S_RSP_DAT: begin
                if (rsp_fire && (byte_cnt_reg == 2'd3)) state_next = S_OP;
            end
            default: state_next = S_OP;
        endcase
    end

    // Bus-cycle timeout counter, running only while a cycle is outstanding
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_cnt_reg <= '0;
        end else if ((state_reg == S_BUS) && !bus_done) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end else begin
            tmo_cnt_reg <= '0;
        end
    end

    // Packet parsing, WB cycle launch/retire and response sequencing
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg     <= S_OP;
            cmd_ready_reg <= 1'b0;
            byte_cnt_reg  <= 2'd0;
            we_reg        <= 1'b0;
            sel_reg       <= 4'h0;
            adr_shift_reg <= 32'h0;
            dat_shift_reg <= 32'h0;
            rd_data_reg   <= 32'h0;
            wbm_cyc_reg   <= 1'b0;
            wbm_we_reg    <= 1'b0;
            wbm_sel_reg   <= 4'h0;
            wbm_adr_reg   <= 32'h0;
            wbm_dat_reg   <= 32'h0;
            rsp_data_reg  <= 8'h00;
            rsp_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cmd_ready_reg <= (state_next == S_OP) || (state_next == S_ADR) || (state_next == S_DAT);
            case (state_reg)
                S_OP: begin
                    if (cmd_fire) begin
                        byte_cnt_reg <= 2'd0;
                        sel_reg      <= cmd_data_i[7:4];
                        we_reg       <= (cmd_data_i[3:0] == 4'h2);
                        if (!op_legal) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_data_reg  <= ST_BAD;
                        end
                    end
                end
                S_ADR: begin
                    if (cmd_fire) begin
                        adr_shift_reg <= {adr_shift_reg[23:0], cmd_data_i};
                        byte_cnt_reg  <= byte_cnt_reg + 2'd1;
                        if ((byte_cnt_reg == 2'd3) && !we_reg) begin
                            wbm_cyc_reg <= 1'b1;
                            wbm_we_reg  <= 1'b0;
                            wbm_sel_reg <= sel_reg;
                            wbm_adr_reg <= {adr_shift_reg[23:0], cmd_data_i};
                            wbm_dat_reg <= dat_shift_reg;
                        end
                    end else if (gap_hit) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= ST_GAP;
                    end
                end
                S_DAT: begin
                    if (cmd_fire) begin
                        dat_shift_reg <= {dat_shift_reg[23:0], cmd_data_i};
                        byte_cnt_reg  <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            wbm_cyc_reg <= 1'b1;
                            wbm_we_reg  <= 1'b1;
                            wbm_sel_reg <= sel_reg;
                            wbm_adr_reg <= adr_shift_reg;
                            wbm_dat_reg <= {dat_shift_reg[23:0], cmd_data_i};
                        end
                    end else if (gap_hit) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= ST_GAP;
                    end
                end
                S_BUS: begin
                    if (bus_done) begin
                        wbm_cyc_reg   <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= bus_status;
                        if (!wbm_err_i && wbm_ack_i) rd_data_reg <= wbm_dat_i;
                    end
                end
                S_RSP_ST: begin
                    if (rsp_fire) begin
                        if (state_next == S_RSP_DAT) begin
                            rsp_data_reg <= rd_data_reg[31:24];
                            rd_data_reg  <= {rd_data_reg[23:0], 8'h00};
                            byte_cnt_reg <= 2'd0;
                        end else begin
                            rsp_valid_reg <= 1'b0;
                        end
                    end
                end
                S_RSP_DAT: begin
                    if (rsp_fire) begin
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (byte_cnt_reg == 2'd3) begin
                            rsp_valid_reg <= 1'b0;
                        end else begin
                            rsp_data_reg <= rd_data_reg[31:24];
                            rd_data_reg  <= {rd_data_reg[23:0], 8'h00};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wbm_cmd_bridge.sv
// Testbench for wbm_cmd_bridge: scoreboard of expected WB cycles and response
// bytes, filled as packets are driven and drained by a WB slave model and a
// response monitor. Build with WBM_CMD_GAP_TIMEOUT_EN to add the gap-abort case.
`timescale 1ns/1ps
module tb_wbm_cmd_bridge;

    localparam int TMO = 16;
    localparam int GAP = 8;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          mode;   // 0 ack, 1 err, 2 no reply (timeout), 3 cut by reset
        int          lat;
        logic [31:0] rdata;
    } wb_txn_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [7:0]  cmd_data_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i;

    int n_checks = 0;
    int n_errors = 0;
    int stall_cnt = 0;
    bit in_cyc = 0;

    wb_txn_t    wb_q[$];
    logic [7:0] rsp_q[$];

    wbm_cmd_bridge #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_data_i(cmd_data_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .rsp_data_o(rsp_data_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Response ready driver: stalls for stall_cnt cycles when asked
    initial begin
        rsp_ready_i = 1'b1;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (stall_cnt > 0) begin
                rsp_ready_i = 1'b0;
                stall_cnt--;
            end else begin
                rsp_ready_i = 1'b1;
            end
        end
    end

    // Response monitor: pops the scoreboard on each handshake, checks hold while stalled
    initial begin
        bit         hold_pending = 0;
        logic [7:0] hold_data = 8'h00;
        logic [7:0] exp_b;
        forever begin
            @(negedge wb_clk_i);
            if (rsp_valid_o) begin
                if (hold_pending) check_value("rsp_hold", {24'h0, rsp_data_o}, {24'h0, hold_data});
                if (rsp_ready_i) begin
                    hold_pending = 0;
                    if (rsp_q.size() == 0) begin
                        check_value("rsp_extra", {24'h0, rsp_data_o}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = rsp_q.pop_front();
                        check_value("rsp_data", {24'h0, rsp_data_o}, {24'h0, exp_b});
                    end
                end else begin
                    hold_pending = 1;
                    hold_data = rsp_data_o;
                end
            end else begin
                if (hold_pending) check_value("rsp_valid_hold", 0, 1);
                hold_pending = 0;
            end
        end
    end

    // WB slave model: checks each cycle against the scoreboard and replies per mode
    initial begin
        wb_txn_t     cur;
        int          cyc_len = 0;
        logic [68:0] saved = '0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_dat_i = 32'h0;
        cur = '{adr: 32'h0, dat: 32'h0, sel: 4'h0, we: 1'b0, mode: 0, lat: 1, rdata: 32'h0};
        forever begin
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (wbm_cyc_o) begin
                check_value("stb_eq_cyc", {31'h0, wbm_stb_o}, 1);
                check_value("ready_in_bus", {31'h0, cmd_ready_o}, 0);
                if (!in_cyc) begin
                    in_cyc = 1;
                    cyc_len = 0;
                    saved = {wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o};
                    if (wb_q.size() == 0) begin
                        check_value("wb_unexpected", 1, 0);
                        cur.mode = 3;
                    end else begin
                        cur = wb_q.pop_front();
                        check_value("wb_adr", wbm_adr_o, cur.adr);
                        check_value("wb_sel", {28'h0, wbm_sel_o}, {28'h0, cur.sel});
                        check_value("wb_we", {31'h0, wbm_we_o}, {31'h0, cur.we});
                        if (cur.we) check_value("wb_dat", wbm_dat_o, cur.dat);
                    end
                end else begin
                    check_value("wb_stable", {31'h0, saved == {wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o}}, 1);
                end
                cyc_len++;
                wbm_dat_i = cur.rdata;
                if (cur.mode == 0 && cyc_len == cur.lat) wbm_ack_i = 1'b1;
                if (cur.mode == 1 && cyc_len == cur.lat) wbm_err_i = 1'b1;
            end else if (in_cyc) begin
                in_cyc = 0;
                if (cur.mode != 3) check_value("wb_len", cyc_len, (cur.mode == 2) ? TMO : cur.lat);
                if (cur.mode == 2) wbm_ack_i = 1'b1;   // late ack after the drop
            end
        end
    end

    // Offer one command byte; caller is positioned just after a posedge
    task automatic send_byte(input logic [7:0] b);
        bit done = 0;
        cmd_data_i = b;
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge wb_clk_i);
            if (cmd_ready_o) done = 1;
            @(posedge wb_clk_i);
            #1;
        end
        cmd_valid_i = 1'b0;
        if (!done) check_value("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (rsp_q.size() != 0 || wb_q.size() != 0 || in_cyc); i++) begin
            @(posedge wb_clk_i);
            #1;
        end
        check_value("drain_rsp", rsp_q.size(), 0);
        check_value("drain_wb", wb_q.size(), 0);
    endtask

    // Push expected results for one packet, drive it, wait for the response
    task automatic run_cmd(input logic [7:0] op, input logic [31:0] adr, input logic [31:0] dat,
                           input int mode, input int lat, input logic [31:0] rdata, input int stall);
        wb_txn_t    t;
        logic       legal, wr;
        logic [7:0] st;
        legal = (op[3:0] == 4'h1) || (op[3:0] == 4'h2);
        wr = (op[3:0] == 4'h2);
        $display("TXN op=%02h adr=%08h dat=%08h mode=%0d lat=%0d stall=%0d", op, adr, dat, mode, lat, stall);
        if (!legal) begin
            rsp_q.push_back(8'hFF);
        end else begin
            t = '{adr: adr, dat: dat, sel: op[7:4], we: wr, mode: mode, lat: lat, rdata: rdata};
            wb_q.push_back(t);
            st = (mode == 1) ? 8'h01 : (mode == 2) ? 8'h02 : 8'h00;
            rsp_q.push_back(st);
            if (!wr && mode == 0) begin
                for (int i = 3; i >= 0; i--) rsp_q.push_back(rdata[i*8 +: 8]);
            end
        end
        send_byte(op);
        if (legal) begin
            for (int i = 3; i >= 0; i--) send_byte(adr[i*8 +: 8]);
            if (wr) for (int i = 3; i >= 0; i--) send_byte(dat[i*8 +: 8]);
        end
        stall_cnt = stall;
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        bit          seen;
        wb_txn_t     t;
        wb_rst_i = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_data_i = 8'h00;
        repeat (3) @(negedge wb_clk_i);
        check_value("rst_cmd_ready", {31'h0, cmd_ready_o}, 0);
        check_value("rst_rsp", {23'h0, rsp_valid_o, rsp_data_o}, 0);
        check_value("rst_wb_ctl", {25'h0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
        check_value("rst_wb_adr", wbm_adr_o, 0);
        check_value("rst_wb_dat", wbm_dat_o, 0);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;

        run_cmd(8'h02, 32'h0000_1004, 32'hDEAD_BEEF, 0, 5, 32'h0, 0);
        run_cmd(8'hF1, 32'h0000_1004, 32'h0, 0, 3, 32'h1234_5678, 0);
        run_cmd(8'hF1, 32'hFFFF_FFF0, 32'h0, 1, 2, 32'hCAFE_F00D, 0);
        run_cmd(8'h51, 32'h0000_0040, 32'h0, 0, 1, 32'hA5A5_0001, 0);
        run_cmd(8'hF1, 32'h8000_0000, 32'h0, 2, 1, 32'h0BAD_0BAD, 0);
        run_cmd(8'h07, 32'h0, 32'h0, 0, 1, 32'h0, 0);
        run_cmd(8'h00, 32'h0, 32'h0, 0, 1, 32'h0, 0);
        run_cmd(8'hF3, 32'h0, 32'h0, 0, 1, 32'h0, 0);
        run_cmd(8'h31, 32'h0000_2000, 32'h0, 0, 2, 32'h8877_6655, 20);
        run_cmd(8'hC2, 32'h0000_3000, 32'h0102_0304, 1, 4, 32'h0, 6);

        for (int k = 0; k < 6; k++) begin
            op = {4'($urandom_range(15, 0)), ($urandom_range(1, 0) != 0) ? 4'h1 : 4'h2};
            run_cmd(op, $urandom, $urandom, int'($urandom_range(1, 0)), int'($urandom_range(6, 1)),
                    $urandom, int'($urandom_range(8, 0)));
        end

`ifdef WBM_CMD_GAP_TIMEOUT_EN
        $display("TXN gap abort: op=F1 with 3 of 4 address bytes");
        rsp_q.push_back(8'h03);
        send_byte(8'hF1);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        repeat (GAP + 4) @(posedge wb_clk_i);
        #1;
        wait_drain();
        run_cmd(8'hF1, 32'h0000_0010, 32'h0, 0, 2, 32'h1357_9BDF, 0);
`endif

        $display("TXN async reset during an open WB cycle");
        t = '{adr: 32'h0000_5000, dat: 32'h0, sel: 4'hF, we: 1'b0, mode: 3, lat: 1, rdata: 32'h0};
        wb_q.push_back(t);
        send_byte(8'hF1);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        send_byte(8'h00);
        t.adr = 32'h0;
        wb_q[0].adr = 32'h0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge wb_clk_i);
            if (wbm_cyc_o) seen = 1;
        end
        check_value("mid_rst_cyc_seen", {31'h0, seen}, 1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check_value("mid_rst_cyc_drop", {30'h0, wbm_cyc_o, wbm_stb_o}, 0);
        check_value("mid_rst_outs", {22'h0, cmd_ready_o, rsp_valid_o, rsp_data_o}, 0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        run_cmd(8'hF1, 32'h0000_0100, 32'h0, 0, 3, 32'hFEDC_BA98, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
